// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared types and constants for the FIFO read-side drain engine.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Contents:
//   rd_state_e     - drain engine FSM state encoding
//   SKID_DEPTH     - number of entries in the output skid buffer
//   SKID_CNT_W     - width of the skid buffer occupancy count
//   skid_occupancy - words committed to the buffer once this cycle settles
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10
  } rd_state_e;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

  // Words that will occupy the skid buffer after this cycle: those already
  // held, plus the read whose data lands this cycle, minus the one the sink
  // takes. One extra bit of headroom so the sum can never wrap.
  function automatic logic [SKID_CNT_W:0] skid_occupancy(
    input logic [SKID_CNT_W-1:0] cnt,
    input logic                  inflight,
    input logic                  pop
  );
    logic [SKID_CNT_W:0] occ;
    occ = {1'b0, cnt} + {{SKID_CNT_W{1'b0}}, inflight} - {{SKID_CNT_W{1'b0}}, pop};
    return occ;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_skid.sv
// rd_skid_buf: 2-entry FIFO-ordered register buffer between the RAM read port and the stream.
// Latency: a pushed word is visible on head_o the cycle after the push (registered head).
// Backpressure: none internally; the caller must never push into a full buffer or pop an empty one.
//
// Ports:
//   clk_i, rst_ni    - clock, asynchronous active-low reset
//   push_i, data_i   - write data_i at the tail
//   pop_i            - drop the head entry
//   clear_i          - discard all entries (wins over push/pop)
//   count_o          - number of valid entries (0..2)
//   head_o           - oldest entry; zero when the buffer is empty after clear/reset
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [SKID_CNT_W-1:0] count_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  localparam logic [SKID_CNT_W-1:0] CNT_ONE  = SKID_CNT_W'(1);
  localparam logic [SKID_CNT_W-1:0] CNT_FULL = SKID_CNT_W'(SKID_DEPTH);

  logic [SKID_CNT_W-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;  // head
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;  // tail when two words are held

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      count_q <= count_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

  always_comb begin
    count_d = count_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    if (clear_i) begin
      // Zero the storage too so discarded data never lingers on head_o.
      count_d = '0;
      ent0_d  = '0;
      ent1_d  = '0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (count_q == '0) begin
            ent0_d = data_i;
          end else begin
            ent1_d = data_i;
          end
          count_d = count_q + CNT_ONE;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          ent1_d  = '0;
          count_d = count_q - CNT_ONE;
        end
        2'b11: begin
          // Occupancy unchanged: the new word becomes head if it was the
          // only one, otherwise the tail shifts up and the new word fills it.
          if (count_q == CNT_ONE) begin
            ent0_d = data_i;
          end else begin
            ent0_d = ent1_q;
            ent1_d = data_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign count_o = count_q;
  assign head_o  = ent0_q;

  // The credit rule upstream keeps a push away from a full buffer.
  a_no_push_full : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !clear_i && count_q == CNT_FULL)
  );

  a_no_pop_empty : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(pop_i && !clear_i && count_q == '0)
  );

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a registered-read FIFO onto a valid/ready stream, with flush and a transfer counter.
// Latency: fifo_rd in cycle N -> word on m_data/m_valid in cycle N+2; sustains one word per cycle.
// Backpressure: m_ready low stops new reads once buffered + in-flight words reach the 2-entry skid depth.
//
// Ports:
//   clk, rst       - clock (rising edge), asynchronous active-low reset
//   en             - level; 1 lets the engine fetch from the FIFO
//   flush          - single-cycle request to discard FIFO and buffered data
//   fifo_empty     - FIFO empty flag
//   fifo_rd        - FIFO read strobe (never asserted while fifo_empty=1)
//   fifo_data      - FIFO read data, valid the cycle after fifo_rd
//   m_valid/m_ready/m_data - output stream, m_data is the skid buffer head
//   busy           - engine active, holding data, or waiting on a read
//   flush_done     - 1-cycle pulse when a flush finishes
//   word_cnt       - wrapping count of stream transfers, cleared only by reset
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic                  flush_done,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  localparam logic [SKID_CNT_W:0] CREDIT_LIMIT = (SKID_CNT_W + 1)'(SKID_DEPTH);

  rd_state_e             state_q, state_d;
  logic                  inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [SKID_CNT_W-1:0] buf_cnt;
  logic                  buf_push;
  logic                  buf_pop;
  logic                  buf_clear;
  logic                  flush_exit;

  // ---------------------------------------------------------------------------
  // State register (FSM, in-flight flag, transfer counter)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // In FLUSH the read strobe equals !fifo_empty, so fifo_empty alone also
  // guarantees no read is being issued in the exit cycle.
  assign flush_exit = (state_q == FLUSH) && fifo_empty && !inflight_q;

  always_comb begin
    state_d = state_q;
    if (flush && state_q != FLUSH) begin
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        IDLE:    if (en)         state_d = RUN;
        RUN:     if (!en)        state_d = IDLE;
        FLUSH:   if (flush_exit) state_d = IDLE;
        default:                 state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    m_valid    = 1'b0;
    buf_pop    = 1'b0;
    fifo_rd    = 1'b0;
    buf_push   = 1'b0;
    buf_clear  = 1'b0;
    flush_done = 1'b0;

    m_valid = (state_q != FLUSH) && (buf_cnt != '0);
    buf_pop = m_valid && m_ready;

    unique case (state_q)
      // Issue a read only if its word will find a free slot when it lands.
      // Counting this cycle's pop lets the stream run at full rate, at the
      // cost of a combinational path from m_ready to fifo_rd.
      RUN:     fifo_rd = !fifo_empty &&
                         (skid_occupancy(buf_cnt, inflight_q, buf_pop) < CREDIT_LIMIT);
      // Drain regardless of buffer space; everything read here is dropped.
      FLUSH:   fifo_rd = !fifo_empty;
      default: fifo_rd = 1'b0;
    endcase

    // Data returning during a flush is discarded rather than buffered.
    buf_push   = inflight_q && (state_q != FLUSH);
    buf_clear  = (state_q == FLUSH);
    flush_done = flush_exit;
  end

  // The RAM has exactly one cycle of read latency, so the flag simply
  // follows the strobe; back-to-back reads keep it set.
  assign inflight_d = fifo_rd;
  assign cnt_d      = cnt_q + {{(CNT_WIDTH-1){1'b0}}, buf_pop};

  rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .clear_i (buf_clear),
    .data_i  (fifo_data),
    .count_o (buf_cnt),
    .head_o  (m_data)
  );

  assign busy     = (state_q != IDLE) || (buf_cnt != '0) || inflight_q;
  assign word_cnt = cnt_q;

  a_rd_not_empty : assert property (
    @(posedge clk) disable iff (!rst)
    !(fifo_rd && fifo_empty)
  );

endmodule
